// File: rtl/score_display_pkg.sv
// score_display_pkg
// Shared constants for the score readout scan driver.
//   BCD_W              : width of one packed BCD digit
//   SEG_0 .. SEG_9     : active-high seven-segment codes {g,f,e,d,c,b,a}
//   SEG_DASH           : error marker shown for nibbles 0xA-0xF
//   SEG_OFF            : all segments dark (active-high sense)
package score_display_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7
// Combinational BCD to seven-segment decoder, active-high output.
// Ports:
//   bcd  in  4  BCD digit; values above 9 decode to a dash
//   code out 7  segment code {g,f,e,d,c,b,a}, code[0] = a
module bcd_to_seg7
    import score_display_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       code
);

    always_comb begin
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display_scan.sv
// score_display_scan
// Time-multiplexed seven-segment scan driver for the score readout.
// Digits are captured into a pending buffer on load and copied into the
// displayed buffer only at a frame boundary, so a frame never mixes old and
// new digits. Each digit slot starts with a short all-off window to stop
// ghosting between neighbouring digits. Optional leading-zero suppression.
// Ports:
//   clk                 in  1             system clock
//   reset               in  1             synchronous, active-high
//   digits_in           in  4*NUM_DIGITS  packed BCD, digit 0 (ones) at [3:0]
//   load                in  1             strobe: capture digits_in into pending
//   blank_leading_zeros in  1             enable leading-zero suppression
//   an                  out NUM_DIGITS    digit selects, an[i] drives digit i
//   seg                 out 7             segments {g,f,e,d,c,b,a}
//   frame_done          out 1             pulse after the last slot of a frame
// All outputs are registered: they reflect the scan state one cycle earlier.
module score_display_scan
    import score_display_pkg::*;
#(
    parameter int NUM_DIGITS       = 8,
    parameter int REFRESH_DIV      = 100000,
    parameter int BLANK_CYCLES     = 16,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic                        load,
    input  logic                        blank_leading_zeros,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [6:0]                  seg,
    output logic                        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BUF_W = BCD_W * NUM_DIGITS;

    // XOR masks that turn active-high intent into board polarity
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]            SEG_POL = {7{SEG_ACTIVE_LOW}};

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [BUF_W-1:0]      pend;
    logic [BUF_W-1:0]      shown;
    logic                  pend_valid;

    logic                  slot_end;
    logic                  frame_end;
    logic                  in_blank;
    logic                  lz_blank;
    logic                  drive;
    logic [BCD_W-1:0]      cur_digit;
    logic [6:0]            cur_code;
    logic [NUM_DIGITS-1:0] sel_onehot;
    logic [NUM_DIGITS-1:0] zero_from;
    logic [NUM_DIGITS-1:0] an_act;
    logic [6:0]            seg_act;

    assign slot_end  = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    assign in_blank  = (int'(cnt) < BLANK_CYCLES);
    assign cur_digit = shown[BCD_W*int'(idx) +: BCD_W];

    // zero_from[i] is set when digits i..NUM_DIGITS-1 of the shown value are all zero
    always_comb begin
        logic z;
        z         = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            z            = z && (shown[BCD_W*i +: BCD_W] == '0);
            zero_from[i] = z;
        end
    end

    // the ones digit always stays lit so a zero score still reads "0"
    assign lz_blank = blank_leading_zeros && (idx != '0) && zero_from[idx];
    assign drive    = !in_blank && !lz_blank;

    always_comb begin
        sel_onehot      = '0;
        sel_onehot[idx] = 1'b1;
    end

    bcd_to_seg7 u_dec (
        .bcd  (cur_digit),
        .code (cur_code)
    );

    assign an_act  = drive ? sel_onehot : '0;
    assign seg_act = drive ? cur_code : SEG_OFF;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            pend       <= '0;
            shown      <= '0;
            pend_valid <= 1'b0;
            frame_done <= 1'b0;
            an         <= AN_POL;
            seg        <= SEG_POL ^ SEG_OFF;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (slot_end) begin
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end

            // shown takes the pending value held before this edge; a load on the
            // boundary cycle refills pend and waits for the following frame
            if (frame_end && pend_valid) begin
                shown <= pend;
            end
            if (load) begin
                pend       <= digits_in;
                pend_valid <= 1'b1;
            end else if (frame_end) begin
                pend_valid <= 1'b0;
            end

            frame_done <= frame_end;
            an         <= AN_POL ^ an_act;
            seg        <= SEG_POL ^ seg_act;
        end
    end

endmodule

// File: tb/tb_score_display_scan.sv
module tb_score_display_scan;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   digits_in;
    logic          load;
    logic          blz;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    // reference model: elapsed cycles since reset plus digit arrays
    int m_t;
    int m_shown[N];
    int m_pend[N];
    bit m_pv;

    logic [6:0] cap_seg[N];
    logic [3:0] cap_lit;

    score_display_scan #(
        .NUM_DIGITS       (N),
        .REFRESH_DIV      (R),
        .BLANK_CYCLES     (B),
        .ANODE_ACTIVE_LOW (1'b1),
        .SEG_ACTIVE_LOW   (1'b1)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .digits_in           (digits_in),
        .load                (load),
        .blank_leading_zeros (blz),
        .an                  (an),
        .seg                 (seg),
        .frame_done          (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hi_code(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // one clock: predict outputs from the model, clock, advance model, compare
    task automatic step();
        logic [3:0] ea;
        logic [6:0] es;
        logic       ef;
        int         pos;
        int         slot;
        bit         lit;
        bit         zabove;
        if (reset) begin
            ea = 4'hF;
            es = 7'h7F;
            ef = 1'b0;
        end else begin
            pos    = m_t % R;
            slot   = (m_t / R) % N;
            zabove = 1'b1;
            for (int i = slot; i < N; i++) if (m_shown[i] != 0) zabove = 1'b0;
            lit = (pos >= B) && !(blz && slot > 0 && zabove);
            ea  = lit ? ~(4'b0001 << slot) : 4'hF;
            es  = lit ? ~hi_code(m_shown[slot]) : 7'h7F;
            ef  = (pos == R - 1) && (slot == N - 1);
        end
        @(posedge clk);
        if (reset) begin
            m_t  = 0;
            m_pv = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_shown[i] = 0;
                m_pend[i]  = 0;
            end
        end else begin
            if (ef && m_pv) begin
                m_shown = m_pend;
                m_pv    = 1'b0;
            end
            if (load) begin
                for (int i = 0; i < N; i++) m_pend[i] = int'((digits_in >> (4 * i)) & 16'hF);
                m_pv = 1'b1;
            end
            m_t++;
        end
        #1;
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(es));
        chk("frame_done", 32'(frame_done), 32'(ef));
    endtask

    task automatic do_load(input logic [15:0] v);
        digits_in = v;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < N * R + 2);
        chk(tag, 32'(frame_done), 32'd1);
    endtask

    // run one full frame, recording which digits lit and with what segments
    task automatic capture_frame();
        cap_lit = '0;
        for (int d = 0; d < N; d++) cap_seg[d] = 'x;
        for (int k = 0; k < N * R; k++) begin
            step();
            for (int d = 0; d < N; d++) begin
                if (an[d] === 1'b0 && cap_lit[d] === 1'b0) begin
                    cap_lit[d] = 1'b1;
                    cap_seg[d] = seg;
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [3:0] exp_lit,
                               input logic [27:0] exp_seg);
        chk({tag, "_lit"}, 32'(cap_lit), 32'(exp_lit));
        for (int d = 0; d < N; d++) begin
            if (exp_lit[d]) chk($sformatf("%s_seg%0d", tag, d), 32'(cap_seg[d]),
                                32'(exp_seg[7*d +: 7]));
        end
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        load      = 1'b0;
        blz       = 1'b0;
        digits_in = '0;
        m_t       = 0;
        m_pv      = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_shown[i] = 0;
            m_pend[i]  = 0;
        end

        // reset held three cycles, then first lit digit
        repeat (3) step();
        reset = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (an === 4'hF && n < 20);
        chk("first_an", 32'(an), 32'(4'b1110));
        chk("first_seg", 32'(seg), 32'(7'h40));

        // plain 1234
        do_load(16'h1234);
        wait_fd("fd_1234");
        capture_frame();
        check_frame("f1234", 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19});

        // leading-zero blanking on 0050
        blz = 1'b1;
        do_load(16'h0050);
        wait_fd("fd_0050");
        capture_frame();
        check_frame("f0050", 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40});

        // all zeros with and without blanking
        do_load(16'h0000);
        wait_fd("fd_0000");
        capture_frame();
        check_frame("f0000_blz", 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        blz = 1'b0;
        capture_frame();
        check_frame("f0000", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40});

        // non-BCD nibble shows a dash
        do_load(16'h00A0);
        wait_fd("fd_00A0");
        capture_frame();
        check_frame("f00A0", 4'b1111, {7'h40, 7'h40, 7'h3F, 7'h40});

        // two loads in one frame: last one wins
        do_load(16'h1111);
        repeat (3) step();
        do_load(16'h2222);
        wait_fd("fd_2222");
        capture_frame();
        check_frame("f2222", 4'b1111, {7'h24, 7'h24, 7'h24, 7'h24});

        // load on the boundary cycle: old pending first, new one a frame later
        do_load(16'h4444);
        repeat (N * R - 2) step();
        do_load(16'h3333);
        chk("fd_coincident", 32'(frame_done), 32'd1);
        capture_frame();
        check_frame("f4444_hold", 4'b1111, {7'h19, 7'h19, 7'h19, 7'h19});
        capture_frame();
        check_frame("f3333", 4'b1111, {7'h30, 7'h30, 7'h30, 7'h30});

        // reset mid-slot discards pending data and restarts at digit 0
        do_load(16'h9876);
        repeat (N * R + 5) step();
        do_load(16'h5555);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        capture_frame();
        check_frame("f_after_reset", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40});

        // randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 31) == 0) blz = ~blz;
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                load = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    digits_in = 16'($urandom);
                end else begin
                    for (int d = 0; d < N; d++)
                        digits_in[4*d +: 4] = ($urandom_range(0, 1) == 1) ? 4'd0
                                              : 4'($urandom_range(0, 9));
                end
            end
            step();
            load  = 1'b0;
            reset = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
